// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
// Shared types and default timing constants for the pushbutton conditioner.
//   btn_state_t : per-channel press/repeat FSM state
//   DEB_10MS, RPT_DLY_500MS, RPT_PER_100MS : default cycle counts at 100 MHz
//   max_u()     : helper used to size the shared hold counter
// ----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HELD      = 2'd1,
      REPEATING = 2'd2
   } btn_state_t;

   localparam int unsigned DEB_10MS      = 32'd1000000;
   localparam int unsigned RPT_DLY_500MS = 32'd50000000;
   localparam int unsigned RPT_PER_100MS = 32'd10000000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_chan.sv
// ----------------------------------------------------------------------------
// btn_chan
// One pushbutton channel: synchroniser, debounce filter and press/repeat FSM.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-high reset
//   btn_raw in  raw asynchronous button level, 1 = pressed
//   rpt_en  in  auto-repeat enable, synchronous to clk
//   level   out debounced level (registered)
//   pulse   out one-cycle strobe on accepted press and on each repeat (registered)
// ----------------------------------------------------------------------------
module btn_chan
   import btn_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
   parameter int unsigned REPEAT_DELAY    = RPT_DLY_500MS,
   parameter int unsigned REPEAT_PERIOD   = RPT_PER_100MS
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   input  logic rpt_en,
   output logic level,
   output logic pulse
);

   localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   // Last count value before the terminal event; the edge that would make the
   // counter reach the full count is the edge that acts.
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] DLY_SAT  = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);
   localparam logic [HOLD_W-1:0] PER_SAT  = HOLD_W'(REPEAT_PERIOD);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   btn_s;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic                   level_q, level_d;
   btn_state_t             state_q, state_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic                   pulse_q, pulse_d;
   logic                   rise, fall;

   // ---------------------------------------------------------------- sync
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
   end

   assign btn_s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------ debounce
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      deb_cnt_d = '0;
      level_d   = level_q;
      if (btn_s != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d = ~level_q;   // counter clears via the default
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // The FSM looks at the level change being registered this edge so that the
   // press pulse lands on the same edge as the level rise.
   assign rise = level_d & ~level_q;
   assign fall = ~level_d & level_q;

   // ------------------------------------------------ FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         deb_cnt_q  <= '0;
         level_q    <= 1'b0;
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         pulse_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         sync_q     <= sync_d;
         deb_cnt_q  <= deb_cnt_d;
         level_q    <= level_d;
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pulse_q    <= pulse_d;
      end
   end

   // ---------------------------------------------- FSM: next-state logic
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      if (fall) begin
         state_d    = IDLE;
         hold_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d    = HELD;
                  hold_cnt_d = '0;
               end
            end
            HELD: begin
               if (hold_cnt_q < DLY_LAST) begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end else if (rpt_en) begin
                  state_d    = REPEATING;
                  hold_cnt_d = '0;
               end else begin
                  // Park at the delay so a late mask set fires on the next edge.
                  hold_cnt_d = DLY_SAT;
               end
            end
            REPEATING: begin
               if (hold_cnt_q < PER_LAST) begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end else if (hold_cnt_q == PER_LAST && rpt_en) begin
                  hold_cnt_d = '0;
               end else begin
                  // Mask was low when the period expired: park here, which
                  // never matches PER_LAST again, so repeats stay off until release.
                  hold_cnt_d = PER_SAT;
               end
            end
            default: begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------- FSM: output logic
   always_comb begin
      pulse_d = 1'b0;
      if (!fall) begin
         case (state_q)
            IDLE:      pulse_d = rise;
            HELD:      pulse_d = (hold_cnt_q >= DLY_LAST) && rpt_en;
            REPEATING: pulse_d = (hold_cnt_q == PER_LAST) && rpt_en;
            default:   pulse_d = 1'b0;
         endcase
      end
   end

   assign level = level_q;
   assign pulse = pulse_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// ----------------------------------------------------------------------------
// btn_pulse_gen
// Multi-channel pushbutton conditioner: N_CH independent btn_chan instances.
// Ports:
//   Clk100M  in  system clock, 100 MHz, rising edge
//   Rst      in  asynchronous active-high reset
//   btn_in   in  [N_CH] raw asynchronous button levels, 1 = pressed
//   rpt_mask in  [N_CH] per-channel auto-repeat enable
//   level    out [N_CH] debounced button levels
//   pulse    out [N_CH] one-cycle press / repeat strobes
// ----------------------------------------------------------------------------
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int unsigned N_CH            = 2,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
   parameter int unsigned REPEAT_DELAY    = RPT_DLY_500MS,
   parameter int unsigned REPEAT_PERIOD   = RPT_PER_100MS
) (
   input  logic            Clk100M,
   input  logic            Rst,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] rpt_mask,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] pulse
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      btn_chan #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_chan (
         .clk     (Clk100M),
         .rst     (Rst),
         .btn_raw (btn_in[i]),
         .rpt_en  (rpt_mask[i]),
         .level   (level[i]),
         .pulse   (pulse[i])
      );
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_btn_pulse_gen
// Scoreboard bench: a window-based reference model predicts debounced levels
// and pulse edges; a monitor compares the DUT against them every cycle.
// ----------------------------------------------------------------------------
module tb_btn_pulse_gen;

   localparam int N_CH = 2;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int RD   = 10;
   localparam int RP   = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] btn_in;
   logic [N_CH-1:0] rpt_mask;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] pulse;

   btn_pulse_gen #(
      .N_CH            (N_CH),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .Clk100M  (clk),
      .Rst      (rst),
      .btn_in   (btn_in),
      .rpt_mask (rpt_mask),
      .level    (level),
      .pulse    (pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Level toggles at edge n when the DEB synchronised samples seen at edges
   // n-DEB .. n-1 all differ from the current level. The synchronised value
   // after edge k is the raw sample taken at edge k-SYNC+1.
   int unsigned abs_edge = 0;
   int          rel_edge = 0;
   bit          hist   [N_CH][$];
   bit          m_lvl  [N_CH];
   int          m_press[N_CH];
   int          m_last [N_CH];
   bit          m_dead [N_CH];
   logic [N_CH-1:0] exp_level = '0;
   int unsigned exp_q  [N_CH][$];
   int          seen   [N_CH];

   function automatic bit s_at(input int ch, input int j);
      int idx;
      idx = j - SYNC + 1;
      if (idx < 1) return 1'b0;
      return hist[ch][idx-1];
   endfunction

   task automatic reset_model();
      rel_edge = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
         hist[ch].delete();
         m_lvl[ch]  = 1'b0;
         m_last[ch] = -1;
         m_dead[ch] = 1'b0;
      end
      exp_level = '0;
   endtask

   task automatic model_edge();
      bit prev;
      bit flip;
      abs_edge++;
      if (rst) begin
         reset_model();
         return;
      end
      rel_edge++;
      for (int ch = 0; ch < N_CH; ch++) begin
         hist[ch].push_back(btn_in[ch]);
         prev = m_lvl[ch];
         flip = 1'b1;
         for (int j = rel_edge - DEB; j < rel_edge; j++)
            if (s_at(ch, j) == prev) flip = 1'b0;
         if (flip) begin
            m_lvl[ch] = ~prev;
            if (!prev) begin
               exp_q[ch].push_back(abs_edge);
               m_press[ch] = rel_edge;
               m_last[ch]  = -1;
               m_dead[ch]  = 1'b0;
            end
         end else if (prev && !m_dead[ch]) begin
            if (m_last[ch] < 0) begin
               if (rel_edge - m_press[ch] >= RD && rpt_mask[ch]) begin
                  exp_q[ch].push_back(abs_edge);
                  m_last[ch] = rel_edge;
               end
            end else if (rel_edge - m_last[ch] == RP) begin
               if (rpt_mask[ch]) begin
                  exp_q[ch].push_back(abs_edge);
                  m_last[ch] = rel_edge;
               end else begin
                  m_dead[ch] = 1'b1;
               end
            end
         end
         exp_level[ch] = m_lvl[ch];
      end
   endtask

   // -------------------------------------------------------------- monitor
   always @(negedge clk) begin
      for (int ch = 0; ch < N_CH; ch++) begin
         check($sformatf("level_ch%0d", ch), 32'(level[ch]), 32'(exp_level[ch]));
         if (pulse[ch] === 1'b1) seen[ch]++;
         if (exp_q[ch].size() > 0 && exp_q[ch][0] == abs_edge) begin
            void'(exp_q[ch].pop_front());
            check($sformatf("pulse_ch%0d_edge%0d", ch, abs_edge), 32'(pulse[ch]), 32'd1);
         end else if (pulse[ch] !== 1'b0) begin
            check($sformatf("stray_pulse_ch%0d_edge%0d", ch, abs_edge), 32'(pulse[ch]), 32'd0);
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic cycle(input logic [N_CH-1:0] b, input logic [N_CH-1:0] m);
      btn_in   = b;
      rpt_mask = m;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic run(input logic [N_CH-1:0] b, input logic [N_CH-1:0] m, input int n);
      for (int i = 0; i < n; i++) cycle(b, m);
   endtask

   int b0, b1;
   logic [N_CH-1:0] tgt, rb, rm;

   initial begin
      rst = 1'b1;
      btn_in = '0;
      rpt_mask = '0;
      reset_model();
      for (int ch = 0; ch < N_CH; ch++) seen[ch] = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_level", 32'(level), 32'd0);
      check("reset_pulse", 32'(pulse), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      // Clean press, no repeat: one pulse at edge 6.
      b0 = seen[0];
      run(2'b01, 2'b00, 8);
      run(2'b00, 2'b00, 12);
      check("clean_press_pulses", 32'(seen[0] - b0), 32'd1);

      // Bounce: never DEB stable samples.
      b0 = seen[0];
      run(2'b01, 2'b00, 3);
      run(2'b00, 2'b00, 1);
      run(2'b01, 2'b00, 3);
      run(2'b00, 2'b00, 12);
      check("bounce_pulses", 32'(seen[0] - b0), 32'd0);

      // Auto-repeat: 6,16,19,22,25,28,31,34; level falls at 36.
      b0 = seen[0];
      run(2'b01, 2'b01, 30);
      run(2'b00, 2'b01, 15);
      check("repeat_pulses", 32'(seen[0] - b0), 32'd8);

      // Mask toggle: mask sampled high at edges 21..29 -> pulses 6,21,24,27.
      b0 = seen[0];
      for (int k = 1; k <= 40; k++) cycle(2'b01, (k >= 21 && k <= 29) ? 2'b01 : 2'b00);
      run(2'b00, 2'b00, 15);
      check("mask_toggle_pulses", 32'(seen[0] - b0), 32'd4);

      // Simultaneous press, only ch0 repeats.
      b0 = seen[0];
      b1 = seen[1];
      run(2'b11, 2'b01, 20);
      run(2'b00, 2'b01, 15);
      check("simul_ch0_pulses", 32'(seen[0] - b0), 32'd5);
      check("simul_ch1_pulses", 32'(seen[1] - b1), 32'd1);

      // Reset in the middle of repeating.
      b0 = seen[0];
      run(2'b01, 2'b01, 20);
      check("pre_reset_pulses", 32'(seen[0] - b0), 32'd3);
      #1 rst = 1'b1;
      reset_model();
      #1;
      check("async_rst_level", 32'(level), 32'd0);
      check("async_rst_pulse", 32'(pulse), 32'd0);
      run(2'b01, 2'b01, 2);
      rst = 1'b0;
      b0 = seen[0];
      run(2'b01, 2'b01, 5);
      check("post_reset_no_early_pulse", 32'(seen[0] - b0), 32'd0);
      run(2'b01, 2'b01, 1);
      check("post_reset_press_pulse", 32'(seen[0] - b0), 32'd1);
      run(2'b01, 2'b00, 4);
      run(2'b00, 2'b00, 15);

      // Random holds with occasional one-cycle glitches and mask changes.
      tgt = '0;
      rm  = '0;
      for (int i = 0; i < 2000; i++) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if ($urandom_range(0, 24) == 0) tgt[ch] = ~tgt[ch];
            rb[ch] = tgt[ch] ^ ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) rm[ch] = ~rm[ch];
         end
         cycle(rb, rm);
      end
      run(2'b00, 2'b00, 15);

      for (int ch = 0; ch < N_CH; ch++)
         check($sformatf("pending_pulses_ch%0d", ch), 32'(exp_q[ch].size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Parametrised multi-channel pushbutton conditioner for the 100 MHz fabric.
- Per channel: 2-flop-style synchroniser, debounce filter, one-cycle press pulse, optional hold-to-auto-repeat.
- Generalises the two-channel up/down blip generator. Sits between the raw board buttons and the counter/control logic that consumes single-cycle increment/decrement strobes.

Parameters:
- N_CH, 2, number of independent button channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms @100 MHz; >=1).
- REPEAT_DELAY, 50000000, cycles from press pulse to first repeat pulse (500 ms; >=2).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (100 ms; >=2).

Ports:
- Clk100M  in  1  system clock, 100 MHz, rising-edge.
- Rst  in  1  reset, asynchronous, active-high.
- btn_in  in  N_CH  raw asynchronous button levels, 1 = pressed.
- rpt_mask  in  N_CH  per-channel auto-repeat enable, synchronous to Clk100M.
- level  out  N_CH  debounced button level.
- pulse  out  N_CH  one-cycle strobe on accepted press and on each repeat.

Behaviour:
- Reset (async, Rst=1): all synchroniser flops, debounce counters, hold counters, level, and pulse go to 0; FSMs go to IDLE. Outputs are registered.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Debounce counter:
  - Increments each cycle while s[i] != level[i].
  - Clears on any cycle where s[i] == level[i].
  - Width is $clog2(DEBOUNCE_CYCLES+1).
  - On the DEBOUNCE_CYCLES-th consecutive mismatch cycle, level[i] toggles at that edge and the counter clears.
- Press latency: level[i] and the press pulse[i] assert at the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising edge, counting as edge 1 the first edge that samples btn_in[i]=1. Release uses the same latency.
- Per-channel FSM:
  - IDLE: level=0. On level 0->1 edge: pulse=1 for exactly that cycle, hold counter cleared -> HELD.
  - HELD: hold counter increments each cycle.
    - Reaches REPEAT_DELAY with rpt_mask[i]=1: pulse=1, counter clears -> REPEATING.
    - Reaches REPEAT_DELAY with rpt_mask[i]=0: counter saturates, no pulse.
  - REPEATING: counter increments each cycle. On reaching REPEAT_PERIOD with rpt_mask[i]=1: pulse=1, counter clears.
  - Any state, level 1->0: -> IDLE, counter cleared, no pulse on release.
- rpt_mask sampling: sampled each cycle. Clearing it in REPEATING suppresses further pulses until release. Setting it in a saturated HELD fires a pulse on the next cycle.
- Pulse timing: for a press pulse at edge P, repeats occur at edges P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_PERIOD, and so on. Pulse is never high on two consecutive cycles.
- Channels are fully independent. Simultaneous presses on all channels produce simultaneous pulses.
- Reset mid-operation: outputs drop immediately. If a button is still held after Rst deasserts, it is re-synchronised and re-debounced and emits a fresh press pulse.
- Hold counter width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).

Decomposition:
- Package btn_pkg:
  - Typedef btn_state_t enum {IDLE, HELD, REPEATING}.
  - Default timing constants: DEB_10MS=1000000, RPT_DLY_500MS=50000000, RPT_PER_100MS=10000000.
- Sub-module btn_chan: one channel (synchroniser, debounce, FSM). Instantiated N_CH times via generate in btn_pulse_gen.

Test Plan:
Bench parameters: N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btn_in[0] 0->1 held 8 cycles, rpt_mask=0 -> level[0]=1 and pulse[0]=1 at edge 6 only; exactly one pulse; level[0] falls 6 edges after release.
- Bounce rejection: btn_in[0] high 3 cycles, low 1, high 3, low -> level[0] and pulse[0] stay 0 throughout.
- Auto-repeat: rpt_mask[0]=1, btn_in[0] held 30 cycles, press pulse at edge P=6 -> pulses at edges 6, 16, 19, 22, 25, ...; none after level falls.
- Mask toggle: hold with rpt_mask[0]=0 past REPEAT_DELAY, set rpt_mask[0]=1 at P+14 -> pulse at P+15, then every 3 cycles; clear mask -> pulses stop.
- Simultaneous channels: both btn_in bits rise on the same edge, rpt_mask=2'b01 -> identical press pulses at edge 6; only channel 0 repeats.
- Reset mid-repeat: assert Rst asynchronously between clocks while in REPEATING with button held -> level and pulse 0 immediately; after deassert, new press pulse 6 edges later.
